// File: rtl/core2wb_pipe_pkg.sv
//------------------------------------------------------------------------------
// core2wb_pipe_pkg
//   Shared types for the pipelined Ibex-to-Wishbone bridge.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package core2wb_pipe_pkg;

    // Largest supported in-flight depth; cnt_t is sized to hold it.
    localparam int c_MAX_OUTST_LIM = 16;

    typedef logic [$clog2(c_MAX_OUTST_LIM + 1)-1:0] cnt_t;

    typedef struct packed {
        logic we;
    } tag_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } to_state_t;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/core2wb_pipe_if.sv
//------------------------------------------------------------------------------
// core2wb_pipe_if
//   Core (req/gnt/rvalid) and Wishbone B4 pipelined signal bundle.
//   master = bridge view (drives Wishbone), slave = core/interconnect view.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface core2wb_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                core_req;
    logic                core_gnt;
    logic                core_we;
    logic [DATA_W/8-1:0] core_be;
    logic [ADDR_W-1:0]   core_addr;
    logic [DATA_W-1:0]   core_wdata;
    logic                core_rvalid;
    logic                core_err;
    logic [DATA_W-1:0]   core_rdata;

    logic                wb_cyc;
    logic                wb_stb;
    logic                wb_we;
    logic [DATA_W/8-1:0] wb_sel;
    logic [ADDR_W-1:0]   wb_adr;
    logic [DATA_W-1:0]   wb_dat_o;
    logic [DATA_W-1:0]   wb_dat_i;
    logic                wb_ack;
    logic                wb_err;
    logic                wb_stall;

    modport master (
        input  core_req, core_we, core_be, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_err, core_rdata,
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o,
        input  wb_dat_i, wb_ack, wb_err, wb_stall
    );

    modport slave (
        output core_req, core_we, core_be, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_err, core_rdata,
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o,
        output wb_dat_i, wb_ack, wb_err, wb_stall
    );
endinterface

`default_nettype wire

// File: rtl/core2wb_pipe_tagfifo.sv
//------------------------------------------------------------------------------
// core2wb_pipe_tagfifo
//   Small synchronous FIFO; push while full is accepted when a pop happens
//   in the same cycle. Read data is the combinational head entry.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module core2wb_pipe_tagfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_rdata,
    output logic                  o_empty,
    output logic                  o_full
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_MEM_N = 1 << c_PTR_W;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [c_MEM_N];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < c_MEM_N; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/core2wb_pipe.sv
//------------------------------------------------------------------------------
// core2wb_pipe
//   Ibex req/gnt/rvalid to pipelined Wishbone B4 bridge, up to MAX_OUTST
//   transfers in flight, in-order responses. Optional response watchdog
//   enabled by defining CORE2WB_PIPE_TIMEOUT_EN.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module core2wb_pipe
    import core2wb_pipe_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_OUTST   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic      clk,
    input  wire logic      rst,
    core2wb_pipe_if.master bus,
    output logic           spurious
);
    if ((DATA_W % 8) != 0 || ADDR_W < 1) begin : g_bad_width
        $error("core2wb_pipe: DATA_W must be a multiple of 8 and ADDR_W positive");
    end
    if (!is_pow2(MAX_OUTST) || MAX_OUTST > c_MAX_OUTST_LIM) begin : g_bad_outst
        $error("core2wb_pipe: MAX_OUTST must be a power of two in 1..16");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("core2wb_pipe: TIMEOUT_CYC must be positive");
    end

    cnt_t r_outst_cnt;
    tag_t w_head;
    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_full;
    logic w_idle;
    logic w_drain;
    logic w_stb;
    logic w_issue;
    logic w_bus_rsp;
    logic w_rsp;
    logic w_pop;

    // Counter and FIFO occupancy move in lockstep; either flag suffices.
    assign w_full    = (r_outst_cnt == cnt_t'(MAX_OUTST)) | w_fifo_full;
    assign w_idle    = (r_outst_cnt == '0) | w_fifo_empty;

    assign w_stb     = bus.core_req & ~w_full & ~w_drain;
    assign w_issue   = w_stb & ~bus.wb_stall;
    assign w_bus_rsp = bus.wb_ack | bus.wb_err;
    assign w_rsp     = w_bus_rsp & ~w_idle & ~w_drain;
    assign w_pop     = w_rsp | w_drain;

    assign bus.core_gnt    = w_issue;
    assign bus.wb_stb      = w_stb;
    assign bus.wb_cyc      = w_stb | (~w_idle & ~w_drain);
    assign bus.wb_we       = bus.core_we;
    assign bus.wb_adr      = bus.core_addr;
    assign bus.wb_dat_o    = bus.core_wdata;
    assign bus.wb_sel      = bus.core_we ? bus.core_be : '1;

    assign bus.core_rvalid = w_pop;
    assign bus.core_err    = bus.wb_err | w_drain;
    assign bus.core_rdata  = (w_rsp & ~w_head.we) ? bus.wb_dat_i : '0;

    core2wb_pipe_tagfifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH ($bits(tag_t))
    ) u_tagfifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_issue),
        .i_wdata (bus.core_we),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outst_cnt <= '0;
            spurious    <= 1'b0;
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_outst_cnt <= r_outst_cnt + cnt_t'(1);
                2'b01:   r_outst_cnt <= r_outst_cnt - cnt_t'(1);
                default: r_outst_cnt <= r_outst_cnt;
            endcase
            // Bus responses with no live transfer to own them are flagged.
            if (w_bus_rsp & (w_idle | w_drain)) begin
                spurious <= 1'b1;
            end
        end
    end

`ifdef CORE2WB_PIPE_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);

    to_state_t         r_state;
    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_to_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_idle | w_rsp) begin
                        r_to_cnt <= '0;
                    end else if (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1)) begin
                        r_to_cnt <= '0;
                        r_state  <= DRAIN;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // One error pulse per entry; leave once the last one pops.
                    if (r_outst_cnt == cnt_t'(1)) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign w_drain = (r_state == DRAIN);
`else
    assign w_drain = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core2wb_pipe.sv
//------------------------------------------------------------------------------
// tb_core2wb_pipe
//   Directed bench with a response scoreboard for core2wb_pipe.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_core2wb_pipe;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int MAX_OUTST   = 4;
    localparam int TIMEOUT_CYC = 16;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spurious;
    int   n_checks = 0;
    int   n_errors = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;

    core2wb_pipe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    core2wb_pipe #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_OUTST   (MAX_OUTST),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.master),
        .spurious (spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.core_req   = 1'b0;
        bus.core_we    = 1'b0;
        bus.core_be    = '0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        bus.wb_dat_i   = '0;
        bus.wb_ack     = 1'b0;
        bus.wb_err     = 1'b0;
        bus.wb_stall   = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.core_req   = 1'b1;
        bus.core_we    = we;
        bus.core_be    = be;
        bus.core_addr  = addr;
        bus.core_wdata = wdata;
    endtask

    // Response monitor: every rvalid must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && bus.core_rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL rsp_unexpected: got err=%0b rdata=0x%0h, expected no response",
                         bus.core_err, bus.core_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.core_err !== mon_e.err || bus.core_rdata !== mon_e.rdata) begin
                    n_errors++;
                    $display("FAIL rsp_data: got err=%0b rdata=0x%0h, expected err=%0b rdata=0x%0h",
                             bus.core_err, bus.core_rdata, mon_e.err, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #3;
        chk("reset_cyc", bus.wb_cyc, 0);
        chk("reset_stb", bus.wb_stb, 0);
        chk("reset_rvalid", bus.core_rvalid, 0);
        chk("reset_spurious", spurious, 0);
        chk("reset_outst", dut.r_outst_cnt, 0);

        // Single read, acked three cycles after the grant.
        step(); drive(1'b0, 4'h0, 32'h1000, 32'h0); #3;
        chk("rd_gnt", bus.core_gnt, 1);
        chk("rd_stb", bus.wb_stb, 1);
        chk("rd_adr", bus.wb_adr, 32'h1000);
        chk("rd_sel_all_ones", bus.wb_sel, 4'hF);
        chk("rd_we", bus.wb_we, 0);
        step(); bus.core_req = 1'b0; #3;
        chk("rd_cyc_held", bus.wb_cyc, 1);
        chk("rd_stb_low", bus.wb_stb, 0);
        step();
        step(); exp_q.push_back('{1'b0, 32'hDEADBEEF}); bus.wb_ack = 1'b1; bus.wb_dat_i = 32'hDEADBEEF;
        step(); bus.wb_ack = 1'b0; bus.wb_dat_i = '0; #3;
        chk("rd_cyc_drop", bus.wb_cyc, 0);

        // Four writes fill the pipe; fifth waits until a slot frees.
        for (int i = 0; i < 4; i++) begin
            step(); drive(1'b1, 4'b0011, 32'h2000 + 32'(4 * i), 32'hA0 + 32'(i)); #3;
            chk("wr_gnt", bus.core_gnt, 1);
            chk("wr_sel", bus.wb_sel, 4'b0011);
            chk("wr_dat_o", bus.wb_dat_o, 32'hA0 + 32'(i));
        end
        step(); drive(1'b1, 4'b0011, 32'h2010, 32'hA4); #3;
        chk("full_stb", bus.wb_stb, 0);
        chk("full_gnt", bus.core_gnt, 0);
        chk("full_outst", dut.r_outst_cnt, 4);
        step(); exp_q.push_back('{1'b0, 32'h0}); bus.wb_ack = 1'b1; bus.wb_dat_i = 32'h12345678; #3;
        chk("full_no_bypass_stb", bus.wb_stb, 0);
        chk("full_no_bypass_gnt", bus.core_gnt, 0);
        step(); bus.wb_ack = 1'b0; #3;
        chk("unfull_stb", bus.wb_stb, 1);
        chk("unfull_gnt", bus.core_gnt, 1);
        for (int i = 0; i < 4; i++) begin
            step(); bus.core_req = 1'b0; bus.wb_ack = 1'b1;
            exp_q.push_back('{1'b0, 32'h0});
        end
        step(); bus.wb_ack = 1'b0; #3;
        chk("wr_cyc_drop", bus.wb_cyc, 0);

        // Mixed W,R,W: only the read returns data.
        step(); drive(1'b1, 4'hF, 32'h3000, 32'h1);
        step(); drive(1'b0, 4'hF, 32'h3004, 32'h0);
        step(); drive(1'b1, 4'hF, 32'h3008, 32'h2);
        step(); bus.core_req = 1'b0; bus.wb_ack = 1'b1; bus.wb_dat_i = 32'h55;
        exp_q.push_back('{1'b0, 32'h0});
        step(); exp_q.push_back('{1'b0, 32'h55});
        step(); exp_q.push_back('{1'b0, 32'h0});
        step(); bus.wb_ack = 1'b0; bus.wb_dat_i = '0; #3;
        chk("mix_cyc_drop", bus.wb_cyc, 0);

        // Stall holds the request for five cycles.
        step(); drive(1'b0, 4'hF, 32'h4000, 32'h0); bus.wb_stall = 1'b1; #3;
        chk("stall_stb", bus.wb_stb, 1);
        chk("stall_gnt", bus.core_gnt, 0);
        for (int i = 0; i < 4; i++) begin
            step(); #3;
            chk("stall_gnt_hold", bus.core_gnt, 0);
        end
        step(); bus.wb_stall = 1'b0; #3;
        chk("stall_release_gnt", bus.core_gnt, 1);
        step(); bus.core_req = 1'b0; #3;
        chk("stall_outst", dut.r_outst_cnt, 1);
        step(); exp_q.push_back('{1'b0, 32'hCAFE0001}); bus.wb_ack = 1'b1; bus.wb_dat_i = 32'hCAFE0001;
        step(); bus.wb_ack = 1'b0; bus.wb_dat_i = '0;

        // Spurious ack, then an errored read, then ack+err together.
        step(); bus.wb_ack = 1'b1; #3;
        chk("spur_no_rvalid", bus.core_rvalid, 0);
        step(); bus.wb_ack = 1'b0; #3;
        chk("spur_set", spurious, 1);
        step(); drive(1'b0, 4'hF, 32'h5000, 32'h0);
        step(); bus.core_req = 1'b0; bus.wb_err = 1'b1; exp_q.push_back('{1'b1, 32'h0});
        step(); bus.wb_err = 1'b0; #3;
        chk("spur_sticky", spurious, 1);
        chk("err_cyc_drop", bus.wb_cyc, 0);
        step(); drive(1'b0, 4'hF, 32'h5004, 32'h0);
        step(); bus.core_req = 1'b0; bus.wb_ack = 1'b1; bus.wb_err = 1'b1; bus.wb_dat_i = 32'h77;
        exp_q.push_back('{1'b1, 32'h77});
        step(); bus.wb_ack = 1'b0; bus.wb_err = 1'b0; bus.wb_dat_i = '0; #3;
        chk("ackerr_single_pop", dut.r_outst_cnt, 0);
        chk("ackerr_cyc_drop", bus.wb_cyc, 0);

        // Reset mid-transfer; the late ack is spurious.
        step(); drive(1'b0, 4'hF, 32'h6000, 32'h0);
        step(); bus.core_req = 1'b0; rst = 1'b1;
        step(); rst = 1'b0; #3;
        chk("midrst_cyc", bus.wb_cyc, 0);
        chk("midrst_spur_clr", spurious, 0);
        step(); bus.wb_ack = 1'b1; bus.wb_dat_i = 32'h99; #3;
        chk("midrst_late_rvalid", bus.core_rvalid, 0);
        step(); bus.wb_ack = 1'b0; bus.wb_dat_i = '0; #3;
        chk("midrst_spur_set", spurious, 1);

`ifdef CORE2WB_PIPE_TIMEOUT_EN
        // Two hung reads are flushed with error responses.
        step(); drive(1'b0, 4'hF, 32'h7000, 32'h0);
        step(); drive(1'b0, 4'hF, 32'h7004, 32'h0);
        step(); bus.core_req = 1'b0;
        exp_q.push_back('{1'b1, 32'h0});
        exp_q.push_back('{1'b1, 32'h0});
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            step(); #3;
            if (bus.core_rvalid) chk("to_drain_cyc", bus.wb_cyc, 0);
        end
        chk("to_drained", exp_q.size(), 0);
        step(); #3;
        chk("to_cyc_low", bus.wb_cyc, 0);
        drive(1'b0, 4'hF, 32'h7008, 32'h0); #1;
        chk("to_regrant", bus.core_gnt, 1);
        step(); bus.core_req = 1'b0; bus.wb_ack = 1'b1; bus.wb_dat_i = 32'h5A;
        exp_q.push_back('{1'b0, 32'h5A});
        step(); bus.wb_ack = 1'b0; bus.wb_dat_i = '0;
`endif

        step(); step(); #3;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
